nf_cdc_rx: RTL and testbench
============================

Name: nf_cdc_rx

Overview:
Destination-side responder for a four-phase req/ack clock-domain-crossing handshake. It lives entirely in the destination clock domain.
- Synchronises a request arriving from a foreign clock domain.
- Captures the foreign data word and returns a registered acknowledge.
- Presents the word to local logic through a valid/ready interface.
- Withholds the acknowledge while its output register is occupied, so no word is ever lost.

Parameters:
width, 8, data word width in bits
sync_stages, 2, number of flops in the req_a synchroniser (legal values 2..4)

Ports:
clk  in  1  destination-domain clock
resetn  in  1  reset, asynchronous, active-low
req_a  in  1  request from the foreign domain; asynchronous to clk
data_a  in  width  foreign data; stable whenever req_a is high
ack_a  out  1  acknowledge to the foreign domain; registered, glitch-free
data_out  out  width  captured word
valid  out  1  data_out holds an unconsumed word
ready  in  1  local consumer accepts data_out on (valid && ready) at a clk edge
busy  out  1  handshake in progress
proto_err  out  1  sticky flag: request withdrawn before it was acknowledged

Behaviour:
- Reset state: when resetn is low, all flops clear immediately (asynchronously): synchroniser, state=IDLE, ack_a=0, data_out=0, valid=0, proto_err=0.
- Synchroniser: req_s is req_a delayed through sync_stages flops. No other signal is synchronised.
- data_a is sampled directly, without synchronisation. This is legal because it is only sampled while req_s=1, and the source holds it stable while req_a is high.
- space = !valid || ready.
- State machine (2 states):
  - IDLE, with req_s=1 and space=1: on the clock edge, data_out<=data_a, valid<=1, ack_a<=1, move to WAIT_LOW.
  - IDLE, with req_s=1 and space=0: stay in IDLE, ack_a stays 0 (backpressure to the foreign domain).
  - IDLE, when req_s falls 1->0 without a capture having occurred: proto_err<=1 (sticky until reset). No capture takes place.
  - WAIT_LOW: ack_a stays 1. When req_s=0: ack_a<=0, move to IDLE. Any ready/valid activity proceeds independently.
- Latency, req_a rising to ack_a rising: minimum sync_stages+1 clk edges. It is sync_stages edges for the synchroniser plus one edge for capture, with space assumed.
- Latency, req_a falling to ack_a falling: sync_stages+1 edges.
- valid and data_out change together, on the same edge as ack_a rises.
- Output register:
  - valid clears on an edge where valid && ready, unless a capture happens on that same edge.
  - A simultaneous consume and capture leaves valid=1, with data_out holding the new word.
  - data_out holds its value while valid=0; it does not clear.
- busy = (state==WAIT_LOW) || req_s.
- One capture per request: a new capture requires the sequence WAIT_LOW -> IDLE followed by req_s=1 again.
- Reset mid-handshake: the block returns to IDLE with ack_a=0 and the word is discarded. If req_a is still high after reset, it is treated as a new request and captured again. The source domain is responsible for tolerating the duplicate.
- Throughput: at most one word per 2*(sync_stages+1) destination clocks, plus source-side latency.

Test Plan:
All scenarios use width=8 and sync_stages=2.
1. Single transfer: ready=1, data_a=0xA5, raise req_a -> ack_a=1, valid=1, data_out=0xA5 on the 3rd edge. Drop req_a -> ack_a=0 on the 3rd edge. valid clears on the next edge.
2. Backpressure: ready=0. Transfer 0x11 completes. Then request with data_a=0x22 -> ack_a stays 0 and data_out stays 0x11 indefinitely. Raise ready -> on that edge data_out=0x22, valid stays 1, ack_a=1.
3. Stream: the foreign source sends 0x01..0x08 using full four-phase cycles, ready=1 -> the consumer sees exactly 0x01..0x08 in order, with no duplicates and no drops. proto_err=0.
4. Reset mid-operation: while in WAIT_LOW with data_out=0x5A, pulse resetn low -> ack_a, valid, data_out and busy go to 0 immediately, without waiting for a clk edge.
5. Withdrawn request: valid=1, ready=0, data_a=0x33. Hold req_a high for 4 cycles, then drop it -> no capture, data_out stays at its old value, proto_err=1 and stays 1 until reset.
6. Simultaneous consume and capture: valid=1 (0x44), ready=1 on the same edge that req_s is first seen high with data_a=0x55 -> valid stays 1, data_out=0x55, ack_a=1.

Source files
------------

// File: rtl/nf_cdc_rx_if.sv
// Handshake bundle for nf_cdc_rx: the foreign-domain req/ack/data side
// plus the local valid/ready output side. The slave modport is the
// receiver's view; the master modport is the view of whatever drives it.
interface nf_cdc_rx_if #(
    parameter int width = 8
);
    logic             req_a;
    logic [width-1:0] data_a;
    logic             ack_a;
    logic [width-1:0] data_out;
    logic             valid;
    logic             ready;

    modport slave (
        input  req_a,
        input  data_a,
        output ack_a,
        output data_out,
        output valid,
        input  ready
    );

    modport master (
        output req_a,
        output data_a,
        input  ack_a,
        input  data_out,
        input  valid,
        output ready
    );
endinterface

// File: rtl/nf_cdc_rx.sv
// Destination-side responder of a four-phase req/ack CDC handshake.
// The request is synchronised into clk; the data word is captured unsynchronised
// because it is only sampled while the synchronised request is high, and the
// source holds it stable for that whole time. The acknowledge is withheld
// while the output register still holds an unconsumed word (backpressure).
module nf_cdc_rx #(
    parameter int width       = 8,
    parameter int sync_stages = 2   // legal range 2..4
) (
    input  logic               clk,
    input  logic               resetn,
    nf_cdc_rx_if.slave         bus,
    output logic               busy,
    output logic               proto_err
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [sync_stages-1:0] sync_r;
    logic                   req_s;
    logic                   req_d_r;
    logic                   space_s;
    logic                   capture_s;
    logic                   ack_clr_s;
    logic                   err_set_s;
    logic                   ack_r;
    logic [width-1:0]       data_r;
    logic                   valid_r;
    logic                   err_r;

    assign req_s   = sync_r[sync_stages-1];
    assign space_s = !valid_r || bus.ready;

    // Request synchroniser plus a one-cycle delayed copy for fall detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_r  <= {sync_stages{1'b0}};
            req_d_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[sync_stages-2:0], bus.req_a};
            req_d_r <= req_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: leave IDLE only on a capture, return once the request drops.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s && space_s) begin
                    state_nxt_s = WAIT_LOW;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!req_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_LOW;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM outputs: capture strobe, ack release, and withdrawn-request detection.
    // A fall of req_s seen while still in IDLE means the request was never taken,
    // because every capture moves the FSM to WAIT_LOW on the same edge.
    always_comb begin
        capture_s = 1'b0;
        ack_clr_s = 1'b0;
        err_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s && space_s) begin
                    capture_s = 1'b1;
                end else begin
                    capture_s = 1'b0;
                end
                if (req_d_r && !req_s) begin
                    err_set_s = 1'b1;
                end else begin
                    err_set_s = 1'b0;
                end
            end
            WAIT_LOW: begin
                if (!req_s) begin
                    ack_clr_s = 1'b1;
                end else begin
                    ack_clr_s = 1'b0;
                end
            end
            default: begin
                capture_s = 1'b0;
                ack_clr_s = 1'b0;
                err_set_s = 1'b0;
            end
        endcase
    end

    // Registered acknowledge so the foreign domain only ever sees a clean flop output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_r <= 1'b0;
        end else if (capture_s) begin
            ack_r <= 1'b1;
        end else if (ack_clr_s) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= ack_r;
        end
    end

    // Output register: a capture wins over a consume on the same edge;
    // data_out keeps its last word once consumed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_r  <= {width{1'b0}};
            valid_r <= 1'b0;
        end else if (capture_s) begin
            data_r  <= bus.data_a;
            valid_r <= 1'b1;
        end else if (valid_r && bus.ready) begin
            data_r  <= data_r;
            valid_r <= 1'b0;
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
        end
    end

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign bus.ack_a    = ack_r;
    assign bus.data_out = data_r;
    assign bus.valid    = valid_r;
    assign busy         = (state_r == WAIT_LOW) || req_s;
    assign proto_err    = err_r;

endmodule

// File: tb/tb_nf_cdc_rx.sv
// Directed self-checking bench for nf_cdc_rx (width=8, sync_stages=2).
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_nf_cdc_rx;

    logic clk;
    logic resetn;
    logic busy;
    logic proto_err;
    int   n_tests;
    int   n_fail;
    bit   collect;
    logic [7:0] rx_q[$];

    nf_cdc_rx_if #(.width(8)) bus ();

    nf_cdc_rx #(.width(8), .sync_stages(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .busy      (busy),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer-side record of every accepted word.
    always @(posedge clk) begin
        if (collect && bus.valid && bus.ready) begin
            rx_q.push_back(bus.data_out);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        bus.req_a  = 1'b0;
        bus.data_a = 8'h00;
        bus.ready  = 1'b0;
        step(2);
        resetn = 1'b1;
    endtask

    // Wait (bounded) for ack_a to reach a level; an expired bound fails the check.
    task automatic wait_ack(input logic v, input string tag);
        int n;
        n = 0;
        while (bus.ack_a !== v && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, bus.ack_a}, {31'd0, v});
    endtask

    // One full four-phase cycle from the foreign source.
    task automatic send_word(input logic [7:0] d, input string tag);
        bus.data_a = d;
        bus.req_a  = 1'b1;
        wait_ack(1'b1, tag);
        bus.req_a  = 1'b0;
        wait_ack(1'b0, tag);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        collect = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        check_eq("rst_ack",   {31'd0, bus.ack_a}, 32'd0);
        check_eq("rst_valid", {31'd0, bus.valid}, 32'd0);
        check_eq("rst_data",  {24'd0, bus.data_out}, 32'h00);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_err",   {31'd0, proto_err}, 32'd0);

        // 1. Single transfer, latency 3 edges each way
        bus.ready  = 1'b1;
        bus.data_a = 8'hA5;
        bus.req_a  = 1'b1;
        step(2);
        check_eq("t1_ack_e2", {31'd0, bus.ack_a}, 32'd0);
        check_eq("t1_busy_e2", {31'd0, busy}, 32'd1);
        step(1);
        check_eq("t1_ack_e3",   {31'd0, bus.ack_a}, 32'd1);
        check_eq("t1_valid_e3", {31'd0, bus.valid}, 32'd1);
        check_eq("t1_data_e3",  {24'd0, bus.data_out}, 32'hA5);
        bus.req_a = 1'b0;
        step(1);
        check_eq("t1_valid_clr", {31'd0, bus.valid}, 32'd0);
        check_eq("t1_data_hold", {24'd0, bus.data_out}, 32'hA5);
        step(1);
        check_eq("t1_ackf_e2", {31'd0, bus.ack_a}, 32'd1);
        step(1);
        check_eq("t1_ackf_e3", {31'd0, bus.ack_a}, 32'd0);
        step(1);
        check_eq("t1_busy_end", {31'd0, busy}, 32'd0);

        // 2. Backpressure
        bus.ready = 1'b0;
        send_word(8'h11, "t2_x11");
        check_eq("t2_valid11", {31'd0, bus.valid}, 32'd1);
        bus.data_a = 8'h22;
        bus.req_a  = 1'b1;
        step(10);
        check_eq("t2_ack_held", {31'd0, bus.ack_a}, 32'd0);
        check_eq("t2_data_held", {24'd0, bus.data_out}, 32'h11);
        check_eq("t2_busy", {31'd0, busy}, 32'd1);
        bus.ready = 1'b1;
        step(1);
        check_eq("t2_data22",  {24'd0, bus.data_out}, 32'h22);
        check_eq("t2_valid22", {31'd0, bus.valid}, 32'd1);
        check_eq("t2_ack22",   {31'd0, bus.ack_a}, 32'd1);
        bus.ready = 1'b0;
        bus.req_a = 1'b0;
        wait_ack(1'b0, "t2_ack_fall");
        check_eq("t2_err", {31'd0, proto_err}, 32'd0);
        bus.ready = 1'b1;
        step(1);
        check_eq("t2_consumed", {31'd0, bus.valid}, 32'd0);

        // 3. Stream of eight words
        rx_q.delete();
        collect = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send_word(i[7:0], "t3_hs");
        end
        step(3);
        collect = 1'b0;
        check_eq("t3_count", rx_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < rx_q.size()) begin
                check_eq("t3_word", {24'd0, rx_q[i]}, i + 1);
            end else begin
                check_eq("t3_word_missing", 32'hFFFF_FFFF, i + 1);
            end
        end
        check_eq("t3_err", {31'd0, proto_err}, 32'd0);

        // 4. Asynchronous reset while in WAIT_LOW
        bus.ready  = 1'b0;
        bus.data_a = 8'h5A;
        bus.req_a  = 1'b1;
        step(3);
        check_eq("t4_pre_ack",  {31'd0, bus.ack_a}, 32'd1);
        check_eq("t4_pre_data", {24'd0, bus.data_out}, 32'h5A);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("t4_ack",   {31'd0, bus.ack_a}, 32'd0);
        check_eq("t4_valid", {31'd0, bus.valid}, 32'd0);
        check_eq("t4_data",  {24'd0, bus.data_out}, 32'h00);
        check_eq("t4_busy",  {31'd0, busy}, 32'd0);
        bus.req_a = 1'b0;
        step(2);
        resetn = 1'b1;
        step(1);

        // 5. Withdrawn request
        bus.ready = 1'b0;
        send_word(8'h77, "t5_x77");
        bus.data_a = 8'h33;
        bus.req_a  = 1'b1;
        step(4);
        check_eq("t5_no_err_yet", {31'd0, proto_err}, 32'd0);
        bus.req_a = 1'b0;
        step(4);
        check_eq("t5_err",   {31'd0, proto_err}, 32'd1);
        check_eq("t5_data",  {24'd0, bus.data_out}, 32'h77);
        check_eq("t5_valid", {31'd0, bus.valid}, 32'd1);
        check_eq("t5_ack",   {31'd0, bus.ack_a}, 32'd0);
        bus.ready = 1'b1;
        step(5);
        check_eq("t5_err_sticky", {31'd0, proto_err}, 32'd1);
        check_eq("t5_consumed", {31'd0, bus.valid}, 32'd0);
        do_reset();
        step(1);
        check_eq("t5_err_rst", {31'd0, proto_err}, 32'd0);

        // 6. Consume and capture on the same edge
        bus.ready = 1'b0;
        send_word(8'h44, "t6_x44");
        check_eq("t6_pre_data", {24'd0, bus.data_out}, 32'h44);
        bus.data_a = 8'h55;
        bus.req_a  = 1'b1;
        step(2);
        bus.ready = 1'b1;
        step(1);
        check_eq("t6_valid", {31'd0, bus.valid}, 32'd1);
        check_eq("t6_data",  {24'd0, bus.data_out}, 32'h55);
        check_eq("t6_ack",   {31'd0, bus.ack_a}, 32'd1);
        bus.req_a = 1'b0;
        wait_ack(1'b0, "t6_ack_fall");
        check_eq("t6_err", {31'd0, proto_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
